keypad_scan: RTL and testbench

- Scans a 4x4 matrix hex keypad and turns debounced key presses into 4-bit hex codes.
- This is the input-side counterpart of the multiplexed 4x7-segment driver. The driver time-multiplexes anode outputs; this block time-multiplexes row drives and reads the column returns.
- Each accepted press is shifted into a 16-bit digit register. That register feeds the segment controller's 16-bit value input directly, so typed digits scroll in from the right.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_scan_sync2.sv | 24 ++
 rtl/keypad_scan.sv | 161 ++++++++++++++++
 tb/tb_keypad_scan.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   localparam logic [3:0] COL_IDLE = 4'hF;

   // Nibble {row,col} holds the hex legend printed on that key.
   localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

   function automatic logic [3:0] map_key(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [5:0] base;
      base = {r, c, 2'b00};
      return KEY_MAP[base +: 4];
   endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for asynchronous inputs, any width.
module sync2 #(
   parameter int              W    = 1,
   parameter logic [W-1:0]    INIT = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= INIT;
         q    <= INIT;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with debounce; accepted keys shift into digits.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [3:0]  row,
   input  logic [3:0]  col,
   input  logic        clr,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down,
   output logic [15:0] digits
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic [3:0]    cs;
   logic [PW-1:0] pre;
   logic          tick;

   state_t        state, state_n;
   logic [1:0]    r, r_n;
   logic [1:0]    c_lat, c_lat_n;
   logic [3:0]    pat, pat_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          accept;

   logic          single;
   logic [1:0]    cidx;

   sync2 #(
      .W    (4),
      .INIT (COL_IDLE)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (col),
      .q     (cs)
   );

   assign tick     = (pre == PRE_MAX);
   assign row      = ~(4'b0001 << r);
   assign key_down = (state == HELD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre <= '0;
      else        pre <= tick ? '0 : pre + 1'b1;
   end

   // Ghosting (two or more columns low) decodes as no key.
   always_comb begin
      single = 1'b0;
      cidx   = 2'd0;
      case (cs)
         4'b1110: begin single = 1'b1; cidx = 2'd0; end
         4'b1101: begin single = 1'b1; cidx = 2'd1; end
         4'b1011: begin single = 1'b1; cidx = 2'd2; end
         4'b0111: begin single = 1'b1; cidx = 2'd3; end
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      r_n     = r;
      c_lat_n = c_lat;
      pat_n   = pat;
      cnt_n   = cnt;
      accept  = 1'b0;
      unique case (state)
         SCAN: begin
            if (tick) begin
               if (single) begin
                  c_lat_n = cidx;
                  pat_n   = cs;
                  cnt_n   = CW'(1);
                  state_n = DEBOUNCE;
               end else begin
                  r_n = r + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (cs == pat) begin
                  if (cnt == CNT_LAST) begin
                     accept  = 1'b1;
                     cnt_n   = '0;
                     state_n = HELD;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n   = '0;
                  r_n     = r + 2'd1;
                  state_n = SCAN;
               end
            end
         end
         HELD: begin
            if (tick) begin
               if (cs == COL_IDLE) begin
                  if (cnt == CNT_LAST) begin
                     cnt_n   = '0;
                     r_n     = r + 2'd1;
                     state_n = SCAN;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
         end
         default: begin
            state_n = SCAN;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SCAN;
         r     <= 2'd0;
         c_lat <= 2'd0;
         pat   <= COL_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         r     <= r_n;
         c_lat <= c_lat_n;
         pat   <= pat_n;
         cnt   <= cnt_n;
      end
   end

   // A clear in the same cycle as an accept still leaves digits empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         digits    <= 16'h0000;
      end else begin
         key_valid <= accept;
         if (accept) key_code <= map_key(r, c_lat);
         if (clr)
            digits <= 16'h0000;
         else if (accept)
            digits <= {digits[11:0], map_key(r, c_lat)};
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with a row-matched key model.
module tb_keypad_scan;

   localparam int SD = 4;
   localparam int DT = 3;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] dig;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        clr;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [15:0] digits;

   logic        key_on;
   logic [3:0]  krow;
   logic [3:0]  kcol;
   logic [15:0] model_dig;
   logic [3:0]  exp_row;
   logic [3:0]  r0;

   exp_t q[$];
   exp_t e;
   int   checks;
   int   failures;
   int   nvalid;

   keypad_scan #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_TICKS (DT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .clr       (clr),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .digits    (digits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A closed switch only pulls its column while its row is driven.
   assign col = (key_on && row == krow) ? kcol : 4'hF;

   task automatic check(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && key_valid) begin
         nvalid++;
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=%0h expected=none",
                     key_code);
         end else begin
            e = q.pop_front();
            check("key_code", 32'(key_code), 32'(e.code));
            check("digits", 32'(digits), 32'(e.dig));
            check("down_at_valid", 32'(key_down), 32'd1);
         end
      end
   end

   task automatic set_key(input int r, input int c);
      krow   = ~(4'b0001 << r);
      kcol   = ~(4'b0001 << c);
      key_on = 1'b1;
   endtask

   task automatic press(
      input int         r,
      input int         c,
      input logic [3:0] code
   );
      model_dig = clr ? 16'h0000 : {model_dig[11:0], code};
      q.push_back('{code: code, dig: model_dig});
      set_key(r, c);
      repeat (40) @(negedge clk);
      check("popped", 32'(q.size()), 32'd0);
      check("key_down_held", 32'(key_down), 32'd1);
      check("row_frozen", 32'(row), 32'(krow));
      key_on = 1'b0;
      repeat (24) @(negedge clk);
      check("key_down_rel", 32'(key_down), 32'd0);
   endtask

   task automatic row_moves(input string nm);
      r0 = row;
      repeat (SD) @(negedge clk);
      check(nm, 32'(row != r0), 32'd1);
   endtask

   task automatic wait_row_enter(input logic [3:0] pat);
      for (int i = 0; i < 40 && row == pat; i++) @(negedge clk);
      for (int i = 0; i < 40 && row != pat; i++) @(negedge clk);
      check("row_align", 32'(row), 32'(pat));
   endtask

   task automatic check_reset_outs(input string nm);
      check({nm, "_row"}, 32'(row), 32'hE);
      check({nm, "_code"}, 32'(key_code), 32'h0);
      check({nm, "_valid"}, 32'(key_valid), 32'h0);
      check({nm, "_down"}, 32'(key_down), 32'h0);
      check({nm, "_digits"}, 32'(digits), 32'h0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      nvalid    = 0;
      rst_n     = 1'b0;
      clr       = 1'b0;
      key_on    = 1'b0;
      krow      = 4'hF;
      kcol      = 4'hF;
      model_dig = 16'h0000;
      repeat (3) @(negedge clk);
      check_reset_outs("rst");
      rst_n = 1'b1;

      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         exp_row = ~(4'b0001 << ((k / SD) % 4));
         check("row_scan", 32'(row), 32'(exp_row));
      end
      check("idle_digits", 32'(digits), 32'h0);

      press(1, 2, 4'h6);
      press(3, 1, 4'hF);
      press(0, 3, 4'hA);
      press(2, 0, 4'h7);
      check("digits_6fa7", 32'(digits), 32'h6FA7);

      for (int i = 0; i < 5; i++) begin
         set_key(0, 0);
         repeat (SD) @(negedge clk);
         key_on = 1'b0;
         repeat (SD) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      row_moves("bounce_row_moves");

      krow   = 4'b1110;
      kcol   = 4'b1001;
      key_on = 1'b1;
      repeat (30) @(negedge clk);
      row_moves("ghost_row_moves");
      key_on = 1'b0;
      repeat (8) @(negedge clk);

      clr = 1'b1;
      press(1, 1, 4'h5);
      check("clr_digits", 32'(digits), 32'h0);
      check("clr_code", 32'(key_code), 32'h5);
      clr = 1'b0;

      wait_row_enter(4'b1110);
      set_key(0, 0);
      repeat (6) @(negedge clk);
      rst_n  = 1'b0;
      key_on = 1'b0;
      #1;
      check_reset_outs("rst_deb");
      @(negedge clk);
      rst_n     = 1'b1;
      model_dig = 16'h0000;
      repeat (30) @(negedge clk);

      model_dig = {model_dig[11:0], 4'h9};
      q.push_back('{code: 4'h9, dig: model_dig});
      set_key(2, 2);
      repeat (40) @(negedge clk);
      check("held_popped", 32'(q.size()), 32'd0);
      check("held_down", 32'(key_down), 32'd1);
      rst_n  = 1'b0;
      key_on = 1'b0;
      #1;
      check_reset_outs("rst_held");
      @(negedge clk);
      rst_n     = 1'b1;
      model_dig = 16'h0000;
      repeat (30) @(negedge clk);

      check("final_queue", 32'(q.size()), 32'd0);
      check("pulse_count", 32'(nvalid), 32'd6);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
